// File: rtl/bios_stream_loader.sv
// Streams the hps_io BIOS download into the Next186 BIOS port: byte pairs -> 16-bit words -> word FIFO.
// Optional feature macro: BIOS_CHECKSUM_EN (adds a running word checksum on bios_csum).
module bios_stream_loader #(
  parameter int WORDS = 8192,
  parameter int DEPTH = 16,
  parameter int INDEX = 0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [12:0] bios_addr,
  output logic [15:0] bios_din,
  output logic        bios_wr,
  input  logic        bios_req,
  output logic        bios_loaded,
  output logic        bios_ovf,
  output logic [15:0] bios_csum
);
  localparam int         PW      = $clog2(DEPTH);
  localparam logic [PW:0] FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0] WAIT_TH = (PW+1)'(DEPTH-2);
  localparam logic [13:0] WMAX    = 14'(WORDS);
  localparam logic [5:0]  IDX     = 6'(INDEX);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic          dl_q, start, fall;
  logic          pending, cap_lo, mk_word;
  logic [7:0]    lo_byte;
  logic [15:0]   word_in, stg_word;
  logic          stg_vld;
  logic [13:0]   acc_cnt, word_cnt;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          push, pop;
  logic          unused;

  assign unused = ^{ioctl_addr[24:1], ioctl_index[7:6]};

  assign start = ioctl_download & ~dl_q & (ioctl_index[5:0] == IDX);
  assign fall  = ~ioctl_download & dl_q;

  always_comb begin
    state_nx = state;
    cap_lo   = 1'b0;
    mk_word  = 1'b0;
    word_in  = {ioctl_dout, lo_byte};
    case (state)
      LOAD: begin
        // An odd-length image leaves a low byte pending; flush it zero-padded on the fall.
        if (fall) begin
          state_nx = DRAIN;
          mk_word  = pending;
          word_in  = {8'h00, lo_byte};
        end else if (ioctl_wr) begin
          cap_lo  = ~ioctl_addr[0];
          mk_word = ioctl_addr[0];
        end
      end
      DRAIN: if (cnt == '0 && !pending && !stg_vld) state_nx = DONE;
      default: ;
    endcase
    if (start) begin
      state_nx = LOAD;
      cap_lo   = 1'b0;
      mk_word  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dl_q        <= 1'b0;
      pending     <= 1'b0;
      lo_byte     <= 8'h00;
      stg_vld     <= 1'b0;
      stg_word    <= 16'h0000;
      acc_cnt     <= '0;
      bios_ovf    <= 1'b0;
      bios_loaded <= 1'b0;
    end else begin
      state <= state_nx;
      dl_q  <= ioctl_download;
      if (start) begin
        pending     <= 1'b0;
        stg_vld     <= 1'b0;
        acc_cnt     <= '0;
        bios_ovf    <= 1'b0;
        bios_loaded <= 1'b0;
      end else begin
        stg_vld <= 1'b0;
        if (cap_lo) begin
          lo_byte <= ioctl_dout;
          pending <= 1'b1;
        end
        // Words past the image size are dropped here, so the FIFO and bios_addr never exceed WORDS.
        if (mk_word) begin
          pending <= 1'b0;
          if (acc_cnt < WMAX) begin
            stg_vld  <= 1'b1;
            stg_word <= word_in;
            acc_cnt  <= acc_cnt + 14'd1;
          end else begin
            bios_ovf <= 1'b1;
          end
        end
        if (state == DRAIN && state_nx == DONE) bios_loaded <= 1'b1;
      end
    end
  end

  assign bios_wr   = (cnt != '0);
  assign bios_din  = bios_wr ? mem[rd_ptr] : 16'h0000;
  assign bios_addr = word_cnt[12:0];
  assign pop       = bios_wr & bios_req;
  assign push      = stg_vld & ((cnt != FULL) | pop);

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= stg_word;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      word_cnt   <= '0;
      ioctl_wait <= 1'b0;
    end else if (start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      word_cnt   <= '0;
      ioctl_wait <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: ;
      endcase
      if (pop && word_cnt < WMAX) word_cnt <= word_cnt + 14'd1;
      // Two free slots remain when this asserts: one staged word plus one in-flight byte pair.
      ioctl_wait <= (cnt >= WAIT_TH);
    end
  end

`ifdef BIOS_CHECKSUM_EN
  logic [15:0] csum;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)   csum <= 16'h0000;
    else if (start) csum <= 16'h0000;
    else if (pop)   csum <= csum + bios_din;
  end
  assign bios_csum = csum;
`else
  assign bios_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_bios_stream_loader.sv
// Scoreboard bench for bios_stream_loader: stimulus queues expected {addr,word}, a monitor checks transfers.
module tb_bios_stream_loader;
  logic        clk_sys = 1'b0, reset_n = 1'b0;
  logic        ioctl_download = 1'b0, dl4 = 1'b0, ioctl_wr = 1'b0, bios_req = 1'b1;
  logic [7:0]  ioctl_index = 8'h00, ioctl_dout = 8'h00;
  logic [24:0] ioctl_addr = '0;

  logic        ioctl_wait, bios_wr, bios_loaded, bios_ovf;
  logic [12:0] bios_addr;
  logic [15:0] bios_din, bios_csum;
  logic        wait4, wr4, loaded4, ovf4;
  logic [12:0] addr4;
  logic [15:0] din4, csum4;

  int          checks = 0, errors = 0;
  logic [28:0] exp_q[$], exp4_q[$];
  logic [28:0] e, e4;
  logic [15:0] sum;

`ifdef BIOS_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  always #5 clk_sys = ~clk_sys;

  bios_stream_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .bios_addr(bios_addr),
    .bios_din(bios_din), .bios_wr(bios_wr), .bios_req(bios_req),
    .bios_loaded(bios_loaded), .bios_ovf(bios_ovf), .bios_csum(bios_csum));

  bios_stream_loader #(.WORDS(4)) dut4 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(dl4),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(wait4), .bios_addr(addr4),
    .bios_din(din4), .bios_wr(wr4), .bios_req(1'b1),
    .bios_loaded(loaded4), .bios_ovf(ovf4), .bios_csum(csum4));

  // Monitor: every accepted word must match the head of its expected queue.
  always @(negedge clk_sys) begin
    if (reset_n && bios_wr && bios_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word unexpected: got addr %0d din %h", bios_addr, bios_din);
      end else begin
        e = exp_q.pop_front();
        if ({bios_addr, bios_din} !== e) begin
          errors++;
          $display("FAIL word: got addr %0d din %h want addr %0d din %h", bios_addr, bios_din, e[28:16], e[15:0]);
        end
      end
    end
    if (reset_n && wr4) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL word4 unexpected: got addr %0d din %h", addr4, din4);
      end else begin
        e4 = exp4_q.pop_front();
        if ({addr4, din4} !== e4) begin
          errors++;
          $display("FAIL word4: got addr %0d din %h want addr %0d din %h", addr4, din4, e4[28:16], e4[15:0]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic push_exp(input bit four, input int a, input logic [15:0] w);
    if (four) exp4_q.push_back({13'(a), w});
    else begin
      exp_q.push_back({13'(a), w});
      sum = sum + w;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx, input bit four);
    ioctl_index = idx;
    if (four) dl4 = 1'b1; else ioctl_download = 1'b1;
    sum = 16'h0000;
    tick();
  endtask

  task automatic end_dl(input bit four);
    if (four) dl4 = 1'b0; else ioctl_download = 1'b0;
    tick();
  endtask

  task automatic send_byte(input int a, input logic [7:0] d);
    int t = 0;
    while (ioctl_wait && t < 1000) begin tick(); t++; end
    if (t >= 1000) begin
      checks++; errors++;
      $display("FAIL wait timeout: ioctl_wait stuck at %0d", ioctl_wait);
    end
    ioctl_addr = 25'(a); ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input bit four);
    int t = 0;
    while (!(four ? loaded4 : bios_loaded) && t < 400) begin tick(); t++; end
    chk(four ? "loaded4" : "loaded", 32'(four ? loaded4 : bios_loaded), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    sum = 16'h0000;
    repeat (3) tick();
    chk("rst wr", 32'(bios_wr), 0);
    chk("rst addr", 32'(bios_addr), 0);
    chk("rst din", 32'(bios_din), 0);
    chk("rst wait", 32'(ioctl_wait), 0);
    chk("rst loaded", 32'(bios_loaded), 0);
    chk("rst ovf", 32'(bios_ovf), 0);
    chk("rst csum", 32'(bios_csum), 0);
    reset_n = 1'b1;
    tick();

    // Test 6: non-matching index is ignored.
    start_dl(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(i, 8'(8'h70 + i));
    chk("t6 wait", 32'(ioctl_wait), 0);
    end_dl(1'b0);
    repeat (10) tick();
    chk("t6 loaded", 32'(bios_loaded), 0);
    chk("t6 addr", 32'(bios_addr), 0);

    // Test 1: 11 22 33 44, plus N+2 latency of the first word.
    start_dl(8'h00, 1'b0);
    push_exp(0, 0, 16'h2211);
    push_exp(0, 1, 16'h4433);
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    chk("t1 lat N+1", 32'(bios_wr), 0);
    tick();
    chk("t1 lat N+2", 32'(bios_wr), 1);
    send_byte(2, 8'h33);
    send_byte(3, 8'h44);
    end_dl(1'b0);
    wait_done(1'b0);
    chk("t1 addr", 32'(bios_addr), 2);
    chk("t1 ovf", 32'(bios_ovf), 0);
    chk("t1 csum", 32'(bios_csum), CS ? 32'h6644 : 32'h0);
    chk("t1 q empty", 32'(exp_q.size()), 0);

    // Test 2: odd length AA BB CC, index bits [7:6] ignored.
    start_dl(8'h40, 1'b0);
    chk("t2 loaded cleared", 32'(bios_loaded), 0);
    push_exp(0, 0, 16'hBBAA);
    push_exp(0, 1, 16'h00CC);
    send_byte(0, 8'hAA);
    send_byte(1, 8'hBB);
    send_byte(2, 8'hCC);
    repeat (4) tick();
    chk("t2 no pad before fall", 32'(bios_wr), 0);
    chk("t2 addr before fall", 32'(bios_addr), 1);
    end_dl(1'b0);
    wait_done(1'b0);
    chk("t2 addr", 32'(bios_addr), 2);
    chk("t2 csum", 32'(bios_csum), CS ? 32'hBC76 : 32'h0);
    chk("t2 q empty", 32'(exp_q.size()), 0);

    // Test 3: back-pressure with bios_req low, 40 bytes.
    bios_req = 1'b0;
    start_dl(8'h00, 1'b0);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          push_exp(0, i, {8'(i * 5 + 3), 8'(i * 5 + 1)});
          send_byte(2 * i, 8'(i * 5 + 1));
          send_byte(2 * i + 1, 8'(i * 5 + 3));
        end
      end
      begin
        repeat (80) tick();
        chk("t3 wait stalled", 32'(ioctl_wait), 1);
        chk("t3 addr stalled", 32'(bios_addr), 0);
        chk("t3 din held", 32'(bios_din), 32'h0301);
        bios_req = 1'b1;
      end
    join
    end_dl(1'b0);
    wait_done(1'b0);
    chk("t3 addr", 32'(bios_addr), 20);
    chk("t3 wait low", 32'(ioctl_wait), 0);
    chk("t3 ovf", 32'(bios_ovf), 0);
    chk("t3 csum", 32'(bios_csum), CS ? 32'(sum) : 32'h0);
    chk("t3 q empty", 32'(exp_q.size()), 0);

    // Test 4: WORDS=4 instance receives 12 bytes.
    start_dl(8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push_exp(1, i, {8'(8'h51 + 2 * i), 8'(8'h50 + 2 * i)});
      send_byte(2 * i, 8'(8'h50 + 2 * i));
      send_byte(2 * i + 1, 8'(8'h51 + 2 * i));
    end
    end_dl(1'b1);
    wait_done(1'b1);
    chk("t4 ovf", 32'(ovf4), 1);
    chk("t4 addr", 32'(addr4), 4);
    chk("t4 q empty", 32'(exp4_q.size()), 0);

    // Test 5: reset in the middle of a download.
    start_dl(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_exp(0, i, {8'(8'h91 + 2 * i), 8'(8'h90 + 2 * i)});
      send_byte(2 * i, 8'(8'h90 + 2 * i));
      send_byte(2 * i + 1, 8'(8'h91 + 2 * i));
    end
    repeat (4) tick();
    send_byte(6, 8'hEE);
    send_byte(7, 8'hEF);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    tick();
    chk("t5 rst wr", 32'(bios_wr), 0);
    chk("t5 rst addr", 32'(bios_addr), 0);
    chk("t5 rst din", 32'(bios_din), 0);
    chk("t5 rst loaded", 32'(bios_loaded), 0);
    chk("t5 rst csum", 32'(bios_csum), 0);
    chk("t5 three words", 32'(exp_q.size()), 0);
    tick();
    reset_n = 1'b1;
    tick();
    start_dl(8'h00, 1'b0);
    push_exp(0, 0, 16'h0201);
    send_byte(0, 8'h01);
    send_byte(1, 8'h02);
    end_dl(1'b0);
    wait_done(1'b0);
    chk("t5 addr", 32'(bios_addr), 1);
    chk("t5 csum", 32'(bios_csum), CS ? 32'h0201 : 32'h0);
    repeat (5) tick();
    chk("t5 q empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
